// File: rtl/bf_pkg.sv
// Shared types and constants for the Brainfuck program memory.
package bf_pkg;

  // Loader states: waiting for a load request, or accepting program bytes.
  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } bfState_e;

  // Instruction encodings (ASCII of the Brainfuck characters), END terminates.
  localparam logic [7:0] OP_INC   = 8'h2B;  // '+'
  localparam logic [7:0] OP_DEC   = 8'h2D;  // '-'
  localparam logic [7:0] OP_RIGHT = 8'h3E;  // '>'
  localparam logic [7:0] OP_LEFT  = 8'h3C;  // '<'
  localparam logic [7:0] OP_JZ    = 8'h5B;  // '['
  localparam logic [7:0] OP_JNZ   = 8'h5D;  // ']'
  localparam logic [7:0] OP_OUT   = 8'h2E;  // '.'
  localparam logic [7:0] OP_IN    = 8'h2C;  // ','
  localparam logic [7:0] OP_END   = 8'h00;  // end of program

endpackage

// File: rtl/bf_prog_ram.sv
// Program byte storage: one write port, one synchronous read port, no reset.
module bf_prog_ram #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              wrEn_i,
  input  logic [ADDR_W-1:0] wrAddr_i,
  input  logic [DATA_W-1:0] wrData_i,
  input  logic [ADDR_W-1:0] rdAddr_i,
  output logic [DATA_W-1:0] rdData_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write the accepted byte and register the read word every cycle.
  always_ff @(posedge clk_i) begin
    if (wrEn_i) begin
      mem[wrAddr_i] <= wrData_i;
    end
    rdData_o <= mem[rdAddr_i];
  end

endmodule

// File: rtl/bf_prog_mem.sv
// Program memory with a streaming loader and a length-masked fetch port.
module bf_prog_mem
  import bf_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addrIn,
  output logic [DATA_W-1:0] dataOut,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              busy,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow
);

  bfState_e          state_q, state_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]   progLen_q, progLen_d;
  logic              overflow_q, overflow_d;
  logic              readValid_q, readValid_d;
  logic              loading;
  logic              accept;
  logic              atEnd;
  logic [DATA_W-1:0] ramData;

  bf_prog_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .wrEn_i  (accept),
    .wrAddr_i(wrPtr_q),
    .wrData_i(load_data),
    .rdAddr_i(addrIn),
    .rdData_o(ramData)
  );

  // A byte is taken only while loading, and never in a cycle that restarts the load.
  always_comb begin
    loading = (state_q == LOAD);
    accept  = load_valid && loading && !load_start;
    atEnd   = &wrPtr_q;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: start (or restart) enters LOAD; the last byte or a full memory ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (load_start) begin
          state_d = LOAD;
        end else if (accept && (load_last || atEnd)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Loader datapath: write pointer, program length and the sticky overflow flag.
  always_comb begin
    wrPtr_d    = wrPtr_q;
    progLen_d  = progLen_q;
    overflow_d = overflow_q;
    if (load_start) begin
      wrPtr_d    = '0;
      progLen_d  = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      wrPtr_d = wrPtr_q + ADDR_W'(1);
      if (load_last) begin
        progLen_d = {1'b0, wrPtr_q} + (ADDR_W+1)'(1);
      end else if (atEnd) begin
        progLen_d  = {1'b1, {ADDR_W{1'b0}}};
        overflow_d = 1'b1;
      end
    end
  end

  // Fetch is only meaningful when idle and inside the loaded program.
  always_comb begin
    readValid_d = !loading && ({1'b0, addrIn} < progLen_q);
  end

  // Loader and fetch-qualifier registers; memory contents are deliberately not reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q     <= '0;
      progLen_q   <= '0;
      overflow_q  <= 1'b0;
      readValid_q <= 1'b0;
    end else begin
      wrPtr_q     <= wrPtr_d;
      progLen_q   <= progLen_d;
      overflow_q  <= overflow_d;
      readValid_q <= readValid_d;
    end
  end

  // Outputs: stale or out-of-range words read as END, and nothing leaks out mid-load.
  always_comb begin
    load_ready = loading;
    busy       = loading;
    prog_len   = progLen_q;
    overflow   = overflow_q;
    dataOut    = (readValid_q && !loading) ? ramData : '0;
  end

endmodule

// File: tb/tb_bf_prog_mem.sv
// Directed testbench for bf_prog_mem (default size plus a 4-byte instance).
module tb_bf_prog_mem;

  logic       clk;
  logic       reset;
  logic [3:0] addrIn;
  logic       load_start;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;

  logic [7:0] dataOut;
  logic       load_ready;
  logic       busy;
  logic [4:0] prog_len;
  logic       overflow;

  logic [7:0] dataOut2;
  logic       loadReady2;
  logic       busy2;
  logic [2:0] progLen2;
  logic       overflow2;

  int checks;
  int failures;

  bf_prog_mem #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .addrIn    (addrIn),
    .dataOut   (dataOut),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .busy      (busy),
    .prog_len  (prog_len),
    .overflow  (overflow)
  );

  bf_prog_mem #(.ADDR_W(2), .DATA_W(8)) dut2 (
    .clk       (clk),
    .reset     (reset),
    .addrIn    (addrIn[1:0]),
    .dataOut   (dataOut2),
    .load_start(load_start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(loadReady2),
    .busy      (busy2),
    .prog_len  (progLen2),
    .overflow  (overflow2)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one cycle of loader inputs, then return them to idle.
  task automatic applyStimulus(input logic s, input logic v, input logic [7:0] d, input logic l);
    load_start = s;
    load_valid = v;
    load_data  = d;
    load_last  = l;
    step();
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) step();
    checks++;
    if ({dataOut, load_ready, busy, prog_len, overflow} !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got dout=%h rdy=%b busy=%b len=%0d ovf=%b expected all zero",
               dataOut, load_ready, busy, prog_len, overflow);
    end
    reset = 1'b0;
    addrIn = 4'd0;
    step();
    checks++;
    if (dataOut !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_read0: got dout=%h busy=%b expected 00/0", dataOut, busy);
    end
  endtask

  task automatic test_basic();
    logic [7:0] prog [5] = '{8'h2B, 8'h2B, 8'h3E, 8'h2D, 8'h2D};
    logic [7:0] expd [6] = '{8'h2B, 8'h2B, 8'h3E, 8'h2D, 8'h2D, 8'h00};
    applyStimulus(1'b1, 1'b1, 8'h5D, 1'b0);
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_start: got rdy=%b busy=%b expected 1/1", load_ready, busy);
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, prog[i], i == 4);
    checks++;
    if (busy !== 1'b0 || prog_len !== 5'd5 || overflow !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_done: got busy=%b len=%0d ovf=%b expected 0/5/0", busy, prog_len, overflow);
    end
    for (int i = 0; i < 6; i++) begin
      addrIn = 4'(i);
      step();
      checks++;
      if (dataOut !== expd[i]) begin
        failures++;
        $display("[TB] FAIL basic_read[%0d]: got %h expected %h", i, dataOut, expd[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] prog [4] = '{8'h2B, 8'h2D, 8'h3E, 8'h3C};
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, prog[i], 1'b0);
    checks++;
    if (busy2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_busy3: got %b expected 1", busy2);
    end
    applyStimulus(1'b0, 1'b1, prog[3], 1'b0);
    checks++;
    if (busy2 !== 1'b0 || loadReady2 !== 1'b0 || progLen2 !== 3'd4 || overflow2 !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ovf_full: got busy=%b rdy=%b len=%0d ovf=%b expected 0/0/4/1",
               busy2, loadReady2, progLen2, overflow2);
    end
    applyStimulus(1'b0, 1'b1, 8'h5B, 1'b0);
    for (int i = 0; i < 4; i++) begin
      addrIn = 4'(i);
      step();
      checks++;
      if (dataOut2 !== prog[i]) begin
        failures++;
        $display("[TB] FAIL ovf_read[%0d]: got %h expected %h", i, dataOut2, prog[i]);
      end
    end
    checks++;
    if (overflow2 !== 1'b1 || progLen2 !== 3'd4) begin
      failures++;
      $display("[TB] FAIL ovf_sticky: got ovf=%b len=%0d expected 1/4", overflow2, progLen2);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (overflow2 !== 1'b0 || progLen2 !== 3'd0) begin
      failures++;
      $display("[TB] FAIL ovf_clear: got ovf=%b len=%0d expected 0/0", overflow2, progLen2);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, prog[i], i == 3);
    checks++;
    if (busy2 !== 1'b0 || progLen2 !== 3'd4 || overflow2 !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_exact_fit: got busy=%b len=%0d ovf=%b expected 0/4/0", busy2, progLen2, overflow2);
    end
  endtask

  task automatic test_valid_gaps();
    logic       vld [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] dat [6] = '{8'h2E, 8'hFF, 8'hEE, 8'h2C, 8'hAA, 8'h5D};
    logic [7:0] expd [4] = '{8'h2E, 8'h2C, 8'h5D, 8'h00};
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, vld[i], dat[i], i == 5);
    checks++;
    if (prog_len !== 5'd3 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL gaps_len: got len=%0d busy=%b expected 3/0", prog_len, busy);
    end
    for (int i = 0; i < 4; i++) begin
      addrIn = 4'(i);
      step();
      checks++;
      if (dataOut !== expd[i]) begin
        failures++;
        $display("[TB] FAIL gaps_read[%0d]: got %h expected %h", i, dataOut, expd[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h2B, 1'b0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_pre_busy: got %b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({dataOut, load_ready, busy, prog_len, overflow} !== 16'h0000) begin
      failures++;
      $display("[TB] FAIL rst_mid_outputs: got dout=%h rdy=%b busy=%b len=%0d ovf=%b expected all zero",
               dataOut, load_ready, busy, prog_len, overflow);
    end
    step();
    reset = 1'b0;
    addrIn = 4'd0;
    step();
    checks++;
    if (dataOut !== 8'h00 || prog_len !== 5'd0) begin
      failures++;
      $display("[TB] FAIL rst_mid_read0: got dout=%h len=%0d expected 00/0", dataOut, prog_len);
    end
  endtask

  task automatic test_restart();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h2B, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h2D, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h3E, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h5B, 1'b0);
    checks++;
    if (busy !== 1'b1 || prog_len !== 5'd0) begin
      failures++;
      $display("[TB] FAIL restart_state: got busy=%b len=%0d expected 1/0", busy, prog_len);
    end
    applyStimulus(1'b0, 1'b1, 8'h3C, 1'b1);
    checks++;
    if (prog_len !== 5'd1 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL restart_len: got len=%0d busy=%b expected 1/0", prog_len, busy);
    end
    addrIn = 4'd0;
    step();
    checks++;
    if (dataOut !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL restart_read0: got %h expected 3c", dataOut);
    end
    addrIn = 4'd1;
    step();
    checks++;
    if (dataOut !== 8'h00) begin
      failures++;
      $display("[TB] FAIL restart_read1: got %h expected 00", dataOut);
    end
  endtask

  task automatic test_hold_addr();
    addrIn = 4'd0;
    step();
    checks++;
    if (dataOut !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL hold_before: got %h expected 3c", dataOut);
    end
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
    checks++;
    if (dataOut !== 8'h00 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL hold_start: got dout=%h busy=%b expected 00/1", dataOut, busy);
    end
    applyStimulus(1'b0, 1'b1, 8'h2E, 1'b0);
    checks++;
    if (dataOut !== 8'h00) begin
      failures++;
      $display("[TB] FAIL hold_loading: got %h expected 00", dataOut);
    end
    applyStimulus(1'b0, 1'b1, 8'h3E, 1'b1);
    checks++;
    if (dataOut !== 8'h00 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_done_edge: got dout=%h busy=%b expected 00/0", dataOut, busy);
    end
    step();
    checks++;
    if (dataOut !== 8'h2E) begin
      failures++;
      $display("[TB] FAIL hold_after: got %h expected 2e", dataOut);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    checks     = 0;
    failures   = 0;
    reset      = 1'b1;
    addrIn     = 4'd0;
    load_start = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_valid_gaps();
    test_reset_mid_load();
    test_restart();
    test_hold_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf_prog_mem.md
BF_PROG_MEM -- requirements
Module: bf_prog_mem

Interface
REQ-001 ADDR_W, default 4, program address width; depth = 2**ADDR_W bytes.
REQ-002 DATA_W, default 8, instruction width in bits.
REQ-003 clk  input  1  the one clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addrIn  input  ADDR_W  instruction fetch address.
REQ-006 dataOut  output  DATA_W  registered instruction at addrIn.
REQ-007 load_start  input  1  single-cycle request to begin a new program load.
REQ-008 load_valid  input  1  load_data holds a valid program byte.
REQ-009 load_data  input  DATA_W  program byte being loaded.
REQ-010 load_last  input  1  qualifies load_data as the final program byte.
REQ-011 load_ready  output  1  block accepts a byte this cycle.
REQ-012 busy  output  1  a load is in progress.
REQ-013 prog_len  output  ADDR_W+1  number of valid program bytes.
REQ-014 overflow  output  1  sticky flag: the last load ran out of space before load_last.

Function
REQ-015 The FSM SHALL have exactly two states: IDLE and LOAD.
REQ-016 In IDLE, load_start SHALL move to LOAD, clear the write pointer, prog_len and overflow; a byte presented in that cycle is not accepted.
REQ-017 load_ready SHALL equal 1 exactly when the state is LOAD; busy SHALL equal load_ready.
REQ-018 A byte SHALL be written to mem[wr_ptr] only when load_valid and load_ready are both 1; wr_ptr then increments by 1.
REQ-019 An accepted byte with load_last=1 SHALL return the FSM to IDLE and set prog_len = wr_ptr+1.
REQ-020 An accepted byte at wr_ptr = 2**ADDR_W-1 with load_last=0 SHALL return the FSM to IDLE, set prog_len = 2**ADDR_W and set overflow.
REQ-021 When load_last=1 coincides with the final address, the load SHALL end as a normal completion with overflow left at 0.
REQ-022 A load_start received in LOAD SHALL restart the load (wr_ptr=0, prog_len=0, overflow=0); any byte presented in that cycle is discarded.
REQ-023 dataOut SHALL update one cycle after addrIn is sampled to mem[addrIn] when busy=0 and addrIn < prog_len, and otherwise to 0x00 (END).
REQ-024 Bytes beyond prog_len SHALL never be visible on dataOut, whatever the stored contents.
REQ-025 overflow SHALL hold its value until the next load_start or reset.

Reset
REQ-026 While reset is asserted: dataOut=0, state=IDLE, wr_ptr=0, prog_len=0, overflow=0, load_ready=0, busy=0.
REQ-027 Memory contents are not reset; REQ-023 guarantees a reset block reads 0x00 at every address.
REQ-028 A reset during LOAD SHALL abandon the load, with prog_len=0 afterwards.

Structure
REQ-029 Shared package bf_pkg SHALL hold the state enum and the opcode constants: 0x2B '+', 0x2D '-', 0x3E '>', 0x3C '<', 0x5B '[', 0x5D ']', 0x2E '.', 0x2C ',', 0x00 END.
REQ-030 Storage SHALL be a sub-module bf_prog_ram: 1 write port, 1 synchronous read port, no reset. The FSM, pointer and output masking stay in bf_prog_mem.

Verification
REQ-031 Load 0x2B,0x2B,0x3E,0x2D,0x2D (last on the 5th byte), then read addresses 0..5 -> dataOut is 2B,2B,3E,2D,2D,00 one cycle after each address; prog_len=5; overflow=0.
REQ-032 ADDR_W=2: load 5 bytes with no load_last -> after the 4th byte state=IDLE, prog_len=4, overflow=1; the 5th byte sees load_ready=0.
REQ-033 load_valid toggling 1,0,0,1,... over a 3-byte load -> only the valid-cycle bytes are stored, in order; prog_len=3.
REQ-034 Assert reset after 2 accepted bytes -> every output reads 0 at once; reading address 0 afterwards gives 0x00.
REQ-035 load_start after 3 accepted bytes, then load 0x3C (last) -> prog_len=1; address 0 reads 0x3C; address 1 reads 0x00.
REQ-036 Hold addrIn=0 during a load -> dataOut=0x00 while busy=1; one cycle after busy falls, dataOut shows the new byte.
